// File: rtl/rect_job_arbiter.sv
// Round-robin arbiter that shares one rectangle-outline generator among N_REQ
// requesters, forwards its coordinate stream tagged with the owner id and aborts hung jobs.
module rect_job_arbiter #(
    parameter  int N_REQ   = 4,
    parameter  int WIDTH   = 32,
    parameter  int TIMEOUT = 65535,
    localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   _clock,
    input  logic                   _reset_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_s_x,
    input  logic [N_REQ*WIDTH-1:0] req_s_y,
    input  logic [N_REQ*WIDTH-1:0] req_height,
    input  logic [N_REQ*WIDTH-1:0] req_width,
    output logic                   gen_start,
    output logic [WIDTH-1:0]       gen_s_x,
    output logic [WIDTH-1:0]       gen_s_y,
    output logic [WIDTH-1:0]       gen_height,
    output logic [WIDTH-1:0]       gen_width,
    input  logic [WIDTH-1:0]       gen_out0,
    input  logic [WIDTH-1:0]       gen_out1,
    input  logic                   gen_valid,
    input  logic                   gen_done,
    output logic [WIDTH-1:0]       _out0,
    output logic [WIDTH-1:0]       _out1,
    output logic                   _valid,
    output logic [ID_W-1:0]        _owner,
    output logic                   job_done,
    output logic                   job_err,
    output logic                   busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);
    localparam logic        WD_EN   = (TIMEOUT != 0);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [ID_W-1:0]  rr_ptr_r;
    logic [ID_W-1:0]  owner_r;
    logic [ID_W-1:0]  next_owner_s;
    logic [ID_W-1:0]  grant_s;
    logic             grant_found_s;
    logic [N_REQ-1:0] req_ready_s;
    logic             hs_s;
    logic             degenerate_s;
    logic [WIDTH-1:0] sel_sx_s;
    logic [WIDTH-1:0] sel_sy_s;
    logic [WIDTH-1:0] sel_h_s;
    logic [WIDTH-1:0] sel_w_s;
    logic [31:0]      wd_cnt_r;
    logic             wd_expire_s;
    logic             err_r;
    logic             fwd_s;
    logic [WIDTH-1:0] sx_r;
    logic [WIDTH-1:0] sy_r;
    logic [WIDTH-1:0] h_r;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] out0_r;
    logic [WIDTH-1:0] out1_r;
    logic             valid_r;
    logic             gen_start_r;
    logic             job_done_r;
    logic             job_err_r;
    logic             busy_r;

    // Round-robin search starting at rr_ptr; the lowest rotation offset wins.
    always_comb begin
        int idx_v;
        idx_v         = 0;
        grant_s       = '0;
        grant_found_s = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_v = (int'(rr_ptr_r) + k) % N_REQ;
            if (req_valid[idx_v]) begin
                grant_s       = ID_W'(idx_v);
                grant_found_s = 1'b1;
            end else begin
                grant_s       = grant_s;
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot ready toward the granted requester, only while idle and out of reset.
    always_comb begin
        req_ready_s = '0;
        if ((state_r == ST_IDLE) && grant_found_s && _reset_n) begin
            req_ready_s[grant_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    assign hs_s     = (state_r == ST_IDLE) && grant_found_s;
    assign sel_sx_s = req_s_x[int'(grant_s)*WIDTH +: WIDTH];
    assign sel_sy_s = req_s_y[int'(grant_s)*WIDTH +: WIDTH];
    assign sel_h_s  = req_height[int'(grant_s)*WIDTH +: WIDTH];
    assign sel_w_s  = req_width[int'(grant_s)*WIDTH +: WIDTH];

    // Non-positive signed size: sign bit set or all zero.
    assign degenerate_s = sel_h_s[WIDTH-1] || (sel_h_s == '0) ||
                          sel_w_s[WIDTH-1] || (sel_w_s == '0);

    assign wd_expire_s  = WD_EN && (state_r == ST_RUN) && (wd_cnt_r == WD_LAST) && !gen_done;
    assign fwd_s        = (state_r == ST_RUN) && gen_valid && !wd_expire_s;
    assign next_owner_s = (owner_r == ID_W'(N_REQ - 1)) ? '0 : owner_r + ID_W'(1);

    // Next-state logic of the job FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    state_nxt_s = degenerate_s ? ST_DONE : ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (gen_done || wd_expire_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state, job latch, round-robin pointer, watchdog and error flag.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= '0;
            owner_r  <= '0;
            sx_r     <= '0;
            sy_r     <= '0;
            h_r      <= '0;
            w_r      <= '0;
            wd_cnt_r <= 32'd0;
            err_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (hs_s) begin
                owner_r <= grant_s;
                sx_r    <= sel_sx_s;
                sy_r    <= sel_sy_s;
                h_r     <= sel_h_s;
                w_r     <= sel_w_s;
            end else begin
                owner_r <= owner_r;
            end
            if (state_r == ST_START) begin
                wd_cnt_r <= 32'd0;
            end else if (state_r == ST_RUN) begin
                wd_cnt_r <= wd_cnt_r + 32'd1;
            end else begin
                wd_cnt_r <= wd_cnt_r;
            end
            if (wd_expire_s) begin
                err_r <= 1'b1;
            end else if (state_r == ST_DONE) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
            if (state_r == ST_DONE) begin
                rr_ptr_r <= next_owner_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Registered outputs; job_done lands in the IDLE cycle following DONE.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            gen_start_r <= 1'b0;
            busy_r      <= 1'b0;
            job_done_r  <= 1'b0;
            job_err_r   <= 1'b0;
            valid_r     <= 1'b0;
            out0_r      <= '0;
            out1_r      <= '0;
        end else begin
            gen_start_r <= (state_nxt_s == ST_START);
            busy_r      <= (state_nxt_s != ST_IDLE);
            job_done_r  <= (state_r == ST_DONE);
            job_err_r   <= (state_r == ST_DONE) && err_r;
            valid_r     <= fwd_s;
            if (fwd_s) begin
                out0_r <= gen_out0;
                out1_r <= gen_out1;
            end else begin
                out0_r <= out0_r;
                out1_r <= out1_r;
            end
        end
    end

    assign req_ready  = req_ready_s;
    assign gen_start  = gen_start_r;
    assign gen_s_x    = sx_r;
    assign gen_s_y    = sy_r;
    assign gen_height = h_r;
    assign gen_width  = w_r;
    assign _out0      = out0_r;
    assign _out1      = out1_r;
    assign _valid     = valid_r;
    assign _owner     = owner_r;
    assign job_done   = job_done_r;
    assign job_err    = job_err_r;
    assign busy       = busy_r;

endmodule
